monitor_scan_controller: RTL and testbench

Sequencer that scans the ADC monitor path. It steps the monitor tile select through a mask of enabled ADC tiles and waits for the select pipeline to settle. It then captures a programmed number of 16*NUMBER_OF_LINE-bit monitor words per tile and streams them to the host capture FIFO over AXI-Stream, tagged with the tile number. It sits between the ADC/DAC monitor block (drives its select, consumes its monitor word) and the PS-side capture buffer.

---
 rtl/monitor_scan_controller.sv | 161 ++++++++++++++++
 tb/tb_monitor_scan_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_scan_controller.sv
// Scans enabled ADC monitor tiles: selects a tile, waits for the select path to settle,
// then streams a fixed number of captured monitor words per tile over AXI-Stream.
module monitor_scan_controller #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int LEN_WIDTH      = 10
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          continuous,
  input  logic                          abort,
  input  logic [7:0]                    channel_mask,
  input  logic [LEN_WIDTH-1:0]          capture_len,
  output logic [2:0]                    monitor_select,
  input  logic [16*NUMBER_OF_LINE-1:0]  monitor_data,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [16*NUMBER_OF_LINE-1:0]  m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [2:0]                    m_axis_tuser,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          cfg_error,
  output logic                          gap_detected
);

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, CAPTURE, NEXT, DONE} state_t;

  state_t               state;
  logic [7:0]           mask_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] load_cnt;
  logic [2:0]           tile;
  logic [3:0]           settle_cnt;

  logic [2:0] first_new;
  logic [2:0] first_latched;
  logic [2:0] next_tile;
  logic       next_found;
  logic       loads_left;
  logic       last_load;

  // Priority search: loops run high to low so the lowest qualifying bit wins.
  always_comb begin
    first_new     = '0;
    first_latched = '0;
    next_tile     = '0;
    next_found    = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (channel_mask[i]) first_new = 3'(i);
      if (mask_q[i]) first_latched = 3'(i);
      if (mask_q[i] && (i > int'(tile))) begin
        next_tile  = 3'(i);
        next_found = 1'b1;
      end
    end
  end

  assign loads_left = (load_cnt < len_q);
  assign last_load  = (load_cnt == (len_q - LEN_WIDTH'(1)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      mask_q         <= '0;
      len_q          <= '0;
      load_cnt       <= '0;
      tile           <= '0;
      settle_cnt     <= '0;
      monitor_select <= '0;
      m_axis_tvalid  <= 1'b0;
      m_axis_tdata   <= '0;
      m_axis_tlast   <= 1'b0;
      m_axis_tuser   <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      cfg_error      <= 1'b0;
      gap_detected   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cfg_error  <= 1'b0;
      if (abort) begin
        // monitor_select deliberately keeps its last value
        state         <= IDLE;
        busy          <= 1'b0;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        load_cnt      <= '0;
        settle_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if ((channel_mask != 8'd0) && (capture_len != '0)) begin
                mask_q       <= channel_mask;
                len_q        <= capture_len;
                gap_detected <= 1'b0;
                tile         <= first_new;
                busy         <= 1'b1;
                state        <= SELECT;
              end else begin
                cfg_error <= 1'b1;
              end
            end
          end
          SELECT: begin
            monitor_select <= tile;
            settle_cnt     <= 4'(SETTLE_CYCLES);
            load_cnt       <= '0;
            state          <= SETTLE;
          end
          SETTLE: begin
            settle_cnt <= settle_cnt - 4'd1;
            if (settle_cnt <= 4'd1) state <= CAPTURE;
          end
          CAPTURE: begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              state         <= NEXT;
            end else if ((!m_axis_tvalid || m_axis_tready) && loads_left) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= monitor_data;
              m_axis_tuser  <= tile;
              m_axis_tlast  <= last_load;
              load_cnt      <= load_cnt + LEN_WIDTH'(1);
            end else if (m_axis_tvalid && m_axis_tready) begin
              m_axis_tvalid <= 1'b0;
            end
            // No sample buffer: a stalled cycle with beats outstanding loses that sample
            if (m_axis_tvalid && !m_axis_tready && loads_left) gap_detected <= 1'b1;
          end
          NEXT: begin
            if (next_found) begin
              tile  <= next_tile;
              state <= SELECT;
            end else begin
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end
          DONE: begin
            if (continuous) begin
              tile  <= first_latched;
              state <= SELECT;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_monitor_scan_controller.sv
// Bench for monitor_scan_controller: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a beat-stream model of each frame.
`timescale 1ns/1ps
module tb_monitor_scan_controller;
  localparam int NL = 8;
  localparam int LW = 10;
  localparam int DW = 16*NL;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          abort = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic [7:0]    channel_mask = '0;
  logic [LW-1:0] capture_len = '0;
  logic [2:0]    monitor_select, m_axis_tuser;
  logic [DW-1:0] monitor_data, m_axis_tdata;
  logic [127:0]  noise = '0;
  logic          m_axis_tvalid, m_axis_tlast, busy, frame_done, cfg_error, gap_detected;

  int errors = 0;
  int checks = 0;

  monitor_scan_controller #(.NUMBER_OF_LINE(NL), .SETTLE_CYCLES(4), .LEN_WIDTH(LW)) dut (
    .clock(clock), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
    .channel_mask(channel_mask), .capture_len(capture_len), .monitor_select(monitor_select),
    .monitor_data(monitor_data), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .frame_done(frame_done), .cfg_error(cfg_error), .gap_detected(gap_detected)
  );

  // Monitor word carries the current select in its low bits and fresh noise above.
  assign monitor_data = {noise[DW-1:3], monitor_select};
  always #5 clock = ~clock;
  always @(negedge clock) noise = {$urandom, $urandom, $urandom, $urandom};

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the expected beats of the running frame, in order.
  int q_tile[$];
  bit q_last[$];
  int acc_log[$];
  bit busy_m = 0, gap_m = 0, cfg_m = 0, done_m = 0;
  int fd_stage = 0;
  logic [7:0] mask_m = '0;
  int len_m = 0;

  logic i_reset, i_start, i_abort, i_cont, i_ready;
  logic [7:0] i_mask;
  logic [LW-1:0] i_len;
  logic [DW-1:0] i_mdata;
  logic o_tvalid = 0, o_tlast = 0;
  logic [2:0] o_tuser = '0;
  logic [DW-1:0] o_tdata = '0;

  task automatic build_frame();
    q_tile.delete();
    q_last.delete();
    for (int t = 0; t < 8; t++)
      if (mask_m[t])
        for (int b = 0; b < len_m; b++) begin
          q_tile.push_back(t);
          q_last.push_back(b == len_m - 1);
        end
  endtask

  always @(posedge clock) begin
    i_reset = reset; i_start = start; i_abort = abort; i_cont = continuous;
    i_ready = m_axis_tready; i_mask = channel_mask; i_len = capture_len; i_mdata = monitor_data;
    #1;
    if (i_reset || reset) begin
      busy_m = 0; gap_m = 0; fd_stage = 0;
      q_tile.delete(); q_last.delete();
    end else begin
      cfg_m = 0; done_m = 0;
      if (i_abort) begin
        busy_m = 0; fd_stage = 0;
        q_tile.delete(); q_last.delete();
      end else if (!busy_m) begin
        if (i_start) begin
          if (i_mask != 0 && i_len != 0) begin
            busy_m = 1; gap_m = 0; mask_m = i_mask; len_m = int'(i_len);
            build_frame();
          end else cfg_m = 1;
        end
      end else begin
        if (fd_stage == 2) begin
          fd_stage = 0;
          if (i_cont) build_frame(); else busy_m = 0;
        end else if (fd_stage == 1) begin
          fd_stage = 2; done_m = 1;
        end
        if (o_tvalid && i_ready) begin
          if (q_tile.size() == 0) check("beat_unexpected", 1, 0);
          else begin
            check("acc_tuser", o_tuser, q_tile[0]);
            check("acc_tlast", o_tlast, q_last[0]);
            acc_log.push_back(int'(o_tuser));
            void'(q_tile.pop_front());
            void'(q_last.pop_front());
            if (q_tile.size() == 0) fd_stage = 1;
          end
        end else if (o_tvalid && q_last.size() > 0 && !q_last[0]) gap_m = 1;
      end
      check("busy", busy, busy_m);
      check("frame_done", frame_done, done_m);
      check("cfg_error", cfg_error, cfg_m);
      check("gap_detected", gap_detected, gap_m);
      if (!busy_m) check("tvalid_idle", m_axis_tvalid, 0);
      if (o_tvalid && !i_ready && !i_abort) begin
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_tdata", m_axis_tdata, o_tdata);
        check("stall_tuser", m_axis_tuser, o_tuser);
        check("stall_tlast", m_axis_tlast, o_tlast);
      end else if (m_axis_tvalid) begin
        if (q_tile.size() == 0) check("new_beat_unexpected", 1, 0);
        else begin
          check("beat_tdata", m_axis_tdata, i_mdata);
          check("beat_tuser", m_axis_tuser, q_tile[0]);
          check("beat_tlast", m_axis_tlast, q_last[0]);
          check("beat_select", monitor_select, q_tile[0]);
        end
      end
    end
    o_tvalid = m_axis_tvalid; o_tlast = m_axis_tlast; o_tuser = m_axis_tuser; o_tdata = m_axis_tdata;
  end

  task automatic cyc();
    @(posedge clock); #2;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin cyc(); n++; end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fd_count, n, base;
    repeat (3) @(negedge clock);
    reset = 0;
    cyc();

    // Test 1: mask 0x05, len 3, tready high
    channel_mask = 8'h05; capture_len = 3; m_axis_tready = 1; continuous = 0;
    start = 1; fd_count = 0; acc_log.delete();
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (k == 1) begin start = 0; check("t1_busy_c1", busy, 1); end
      if (k >= 6 && k <= 10) begin
        check($sformatf("t1_tvalid_c%0d", k), m_axis_tvalid, (k >= 7 && k <= 9));
        check($sformatf("t1_tlast_c%0d", k), m_axis_tlast, (k == 9));
        if (k >= 7 && k <= 9) check($sformatf("t1_tuser_c%0d", k), m_axis_tuser, 0);
      end
      if (frame_done) fd_count++;
    end
    check("t1_frame_done_count", fd_count, 1);
    check("t1_busy_end", busy, 0);
    check("t1_beats", acc_log.size(), 6);
    if (acc_log.size() == 6) check("t1_tile2_tuser", acc_log[5], 2);

    // Test 2: single tile 7, len 4, tready toggling
    channel_mask = 8'h80; capture_len = 4; start = 1; acc_log.delete();
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (k == 1) start = 0;
      m_axis_tready = (k % 2 == 1);
    end
    m_axis_tready = 1;
    wait_idle(50);
    check("t2_beats", acc_log.size(), 4);
    foreach (acc_log[i]) check($sformatf("t2_tuser_%0d", i), acc_log[i], 7);
    check("t2_gap", gap_detected, 1);

    // Test 3: rejected starts
    channel_mask = 8'h00; capture_len = 3; start = 1;
    cyc(); start = 0;
    check("t3_cfg_error_mask", cfg_error, 1);
    check("t3_busy_mask", busy, 0);
    cyc();
    check("t3_cfg_error_clear", cfg_error, 0);
    channel_mask = 8'h05; capture_len = 0; start = 1;
    cyc(); start = 0;
    check("t3_cfg_error_len", cfg_error, 1);
    check("t3_tvalid_len", m_axis_tvalid, 0);
    cyc();
    check("t3_cfg_error_clear2", cfg_error, 0);

    // Test 4: continuous frames, mask 0x03, len 2
    channel_mask = 8'h03; capture_len = 2; continuous = 1; start = 1;
    acc_log.delete(); fd_count = 0; n = 0;
    while (fd_count < 3 && n < 300) begin
      cyc(); n++;
      if (n == 1) start = 0;
      if (frame_done) fd_count++;
    end
    continuous = 0;
    check("t4_frames", fd_count, 3);
    wait_idle(50);
    check("t4_beats", acc_log.size(), 12);
    foreach (acc_log[i]) check($sformatf("t4_tuser_%0d", i), acc_log[i], ((i % 4) >= 2) ? 1 : 0);

    // Test 5: abort mid-capture of tile 1, then restart
    channel_mask = 8'h03; capture_len = 5; start = 1; n = 0;
    cyc(); start = 0;
    while (!(m_axis_tvalid && m_axis_tuser == 3'd1) && n < 100) begin cyc(); n++; end
    check("t5_reach_tile1", m_axis_tuser, 1);
    abort = 1;
    cyc(); abort = 0;
    check("t5_tvalid_after_abort", m_axis_tvalid, 0);
    check("t5_busy_after_abort", busy, 0);
    check("t5_select_held", monitor_select, 1);
    start = 1; n = 0;
    cyc(); start = 0;
    while (!m_axis_tvalid && n < 50) begin cyc(); n++; end
    check("t5_restart_tuser", m_axis_tuser, 0);
    check("t5_restart_tvalid", m_axis_tvalid, 1);
    wait_idle(100);

    // Test 6: asynchronous reset in SETTLE
    channel_mask = 8'h10; capture_len = 2; start = 1;
    cyc(); start = 0;
    cyc(); cyc();
    check("t6_select_before_reset", monitor_select, 4);
    #1 reset = 1;
    #1;
    check("t6_rst_select", monitor_select, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_tvalid", m_axis_tvalid, 0);
    check("t6_rst_tdata", m_axis_tdata, 0);
    check("t6_rst_tlast", m_axis_tlast, 0);
    check("t6_rst_tuser", m_axis_tuser, 0);
    check("t6_rst_flags", {frame_done, cfg_error, gap_detected}, 0);
    @(posedge clock); @(negedge clock);
    reset = 0;
    cyc();

    // Random traffic
    for (int k = 0; k < 2500; k++) begin
      m_axis_tready = ($urandom_range(0, 9) < 7);
      start = ($urandom_range(0, 7) == 0);
      channel_mask = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      capture_len = ($urandom_range(0, 12) == 0) ? '0 : LW'($urandom_range(1, 5));
      continuous = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 59) == 0);
      cyc();
    end
    start = 0; abort = 0; continuous = 0; m_axis_tready = 1;
    cyc(); cyc();
    base = checks;
    wait_idle(2000);
    repeat (3) cyc();
    check("final_idle_busy", busy, 0);
    check("final_checks_progress", (checks > base), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
